// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory copy engine.
// The optional fill feature is enabled by defining DM_FILL_EN.
package dm_pkg;

    localparam int DM_AW    = 8;
    localparam int DM_DW    = 8;
    localparam int DM_LEN_W = 9;
    localparam int DM_DEPTH = 256;

    // Engine sequencing: one READ plus one WRITE per copied byte.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dm_state_e;

endpackage

// File: rtl/dm_copy_engine_if.sv
// Data-memory port bundle: the engine drives address/write/data and
// samples the memory's combinational read data.
interface dm_copy_engine_if
    import dm_pkg::*;
#(
    parameter int AW = DM_AW,
    parameter int DW = DM_DW
);

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dm_copy_engine.sv
// Block copy DMA engine for the 8-bit data-memory port. Copies len bytes
// forward from src to dst at two cycles per byte; pointers wrap mod 256.
// Defining DM_FILL_EN adds a fill mode that writes fill_value at one
// cycle per byte without reading memory.
module dm_copy_engine
    import dm_pkg::*;
#(
    parameter int AW    = DM_AW,
    parameter int DW    = DM_DW,
    parameter int LEN_W = DM_LEN_W
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [AW-1:0]     i_src_addr,
    input  logic [AW-1:0]     i_dst_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_fill_mode,
    input  logic [DW-1:0]     i_fill_value,
    dm_copy_engine_if.master  mem,
    output logic              o_busy,
    output logic              o_done,
    output logic [LEN_W-1:0]  o_remaining
);

    dm_state_e        r_state;
    logic [AW-1:0]    r_src_ptr;
    logic [AW-1:0]    r_dst_ptr;
    logic [AW-1:0]    r_mem_addr;
    logic             r_mem_we;
    logic [DW-1:0]    r_mem_wdata;
    logic             r_busy;
    logic             r_done;
    logic [LEN_W-1:0] r_remaining;

`ifdef DM_FILL_EN
    logic             r_fill;
    logic [DW-1:0]    r_fill_value;
`else
    logic             w_unused_fill;
    assign w_unused_fill = ^{i_fill_mode, i_fill_value};
`endif

    // Transfer sequencer; memory-port controls are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_src_ptr   <= i_src_addr;
                        r_dst_ptr   <= i_dst_addr;
                        r_remaining <= i_len;
                        r_busy      <= 1'b1;
`ifdef DM_FILL_EN
                        r_fill       <= i_fill_mode;
                        r_fill_value <= i_fill_value;
`endif
                        if (i_len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
`ifdef DM_FILL_EN
                        end else if (i_fill_mode) begin
                            r_state     <= WRITE;
                            r_mem_addr  <= i_dst_addr;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= i_fill_value;
`endif
                        end else begin
                            r_state    <= READ;
                            r_mem_addr <= i_src_addr;
                            r_mem_we   <= 1'b0;
                        end
                    end
                end
                READ: begin
                    // Memory read is combinational, so the byte is captured straight into the write data.
                    r_mem_wdata <= mem.mem_rdata;
                    r_src_ptr   <= r_src_ptr + AW'(1);
                    r_mem_addr  <= r_dst_ptr;
                    r_mem_we    <= 1'b1;
                    r_state     <= WRITE;
                end
                WRITE: begin
                    r_dst_ptr   <= r_dst_ptr + AW'(1);
                    r_remaining <= r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        r_mem_we <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
`ifdef DM_FILL_EN
                    end else if (r_fill) begin
                        r_mem_addr  <= r_dst_ptr + AW'(1);
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= r_fill_value;
`endif
                    end else begin
                        r_mem_addr <= r_src_ptr;
                        r_mem_we   <= 1'b0;
                        r_state    <= READ;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_wdata = r_mem_wdata;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_remaining   = r_remaining;

endmodule
